// File: rtl/mem_req_queue_if.sv
// Handshake and bus bundle for the data-memory request queue.
// slave = the queue itself, master = the EX/MEM/bus environment around it.
interface mem_req_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  // EX-side request
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_we;
  logic [1:0]            in_size;
  logic                  in_unsigned;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_wdata;
  logic [RD_W-1:0]       in_rd;
  // SRAM-style bus
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;
  // MEM-side response
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_data;
  logic [RD_W-1:0]       resp_rd;
  logic                  resp_we;
  logic                  resp_ale;
  logic [ADDR_W-1:0]     resp_vaddr;

  modport slave (
    input  in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  addr_ok, data_ok, rdata, resp_ready,
    output in_ready, req, wr, size, wstrb, addr, wdata,
    output resp_valid, resp_data, resp_rd, resp_we, resp_ale, resp_vaddr
  );

  modport master (
    output in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output addr_ok, data_ok, rdata, resp_ready,
    input  in_ready, req, wr, size, wstrb, addr, wdata,
    input  resp_valid, resp_data, resp_rd, resp_we, resp_ale, resp_vaddr
  );
endinterface

// File: rtl/mem_req_queue.sv
// Data-memory request unit: issues EX loads/stores on a req/addr_ok/data_ok
// bus, tracks up to DEPTH outstanding requests in order, and hands
// extended load data / store completion / misalignment back to MEM.
module mem_req_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter int RD_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  mem_req_queue_if.slave   bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // Queue bookkeeping
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d, ent_done_q, ent_done_d, ent_disc_q, ent_disc_d;

  // Entry payload
  logic              ent_we_q    [DEPTH];
  logic [1:0]        ent_size_q  [DEPTH];
  logic              ent_uns_q   [DEPTH];
  logic [OFF_W-1:0]  ent_off_q   [DEPTH];
  logic [RD_W-1:0]   ent_rd_q    [DEPTH];
  logic [ADDR_W-1:0] ent_vaddr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q  [DEPTH];

  // Misaligned-operation holding register
  logic              ale_valid_q, ale_valid_d;
  logic              ale_we_q;
  logic [RD_W-1:0]   ale_rd_q;
  logic [ADDR_W-1:0] ale_vaddr_q;

  logic ale, full, empty, push, ale_take, fill, pop;
  logic head_done, head_live;
  logic [STRB_W-1:0] strb_base;
  logic [DATA_W-1:0] lane, ext;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Misalignment detect, strobes and replicated write data
  always_comb begin
    ale       = 1'b0;
    strb_base = '0;
    bus.wdata = bus.in_wdata;
    case (bus.in_size)
      2'd0: begin
        strb_base = STRB_W'(1);
        bus.wdata = {STRB_W{bus.in_wdata[7:0]}};
      end
      2'd1: begin
        ale       = bus.in_addr[0];
        strb_base = STRB_W'(3);
        bus.wdata = {(DATA_W/16){bus.in_wdata[15:0]}};
      end
      2'd2: begin
        ale       = |bus.in_addr[1:0];
        strb_base = STRB_W'(15);
        bus.wdata = {(DATA_W/32){bus.in_wdata[31:0]}};
      end
      default: begin
        ale       = |bus.in_addr[2:0];
        strb_base = STRB_W'(8'hFF);
        bus.wdata = bus.in_wdata;
      end
    endcase
    bus.wstrb = strb_base << bus.in_addr[OFF_W-1:0];
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign bus.req   = resetn & bus.in_valid & ~ale & ~flush & ~full & ~ale_valid_q;
  assign ale_take  = resetn & bus.in_valid & ale & empty & ~ale_valid_q & ~flush;
  assign push      = bus.req & bus.addr_ok;
  assign bus.in_ready = push | ale_take;
  assign bus.wr    = bus.in_we;
  assign bus.size  = bus.in_size;
  assign bus.addr  = bus.in_addr;

  // data_ok with nothing waiting is ignored rather than corrupting an entry
  assign fill      = bus.data_ok & ent_vld_q[fill_q] & ~ent_done_q[fill_q];
  assign head_done = ent_vld_q[head_q] & ent_done_q[head_q];
  assign head_live = head_done & ~ent_disc_q[head_q];
  // ale_valid only rises with an empty queue, so it never competes with the head
  assign pop       = head_done & (ent_disc_q[head_q] | (~ale_valid_q & bus.resp_ready));

  // Next-state for pointers, count, entry flags and the ale register
  always_comb begin
    head_d      = pop  ? ptr_inc(head_q) : head_q;
    tail_d      = push ? ptr_inc(tail_q) : tail_q;
    fill_d      = fill ? ptr_inc(fill_q) : fill_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    ent_vld_d   = ent_vld_q;
    ent_done_d  = ent_done_q;
    ent_disc_d  = ent_disc_q;
    ale_valid_d = ale_valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && tail_q == PTR_W'(i)) begin
        ent_vld_d[i]  = 1'b1;
        ent_done_d[i] = 1'b0;
        ent_disc_d[i] = 1'b0;
      end
      if (fill && fill_q == PTR_W'(i)) ent_done_d[i] = 1'b1;
      if (flush && ent_vld_q[i])       ent_disc_d[i] = 1'b1;
      if (pop && head_q == PTR_W'(i))  ent_vld_d[i]  = 1'b0;
    end
    if (flush)                              ale_valid_d = 1'b0;
    else if (ale_take)                      ale_valid_d = 1'b1;
    else if (ale_valid_q && bus.resp_ready) ale_valid_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      ent_vld_q   <= '0;
      ent_done_q  <= '0;
      ent_disc_q  <= '0;
      ale_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      ent_vld_q   <= ent_vld_d;
      ent_done_q  <= ent_done_d;
      ent_disc_q  <= ent_disc_d;
      ale_valid_q <= ale_valid_d;
    end
  end

  // Payload capture on push/fill/ale acceptance; contents are don't-care until flagged valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && tail_q == PTR_W'(i)) begin
        ent_we_q[i]    <= bus.in_we;
        ent_size_q[i]  <= bus.in_size;
        ent_uns_q[i]   <= bus.in_unsigned;
        ent_off_q[i]   <= bus.in_addr[OFF_W-1:0];
        ent_rd_q[i]    <= bus.in_rd;
        ent_vaddr_q[i] <= bus.in_addr;
      end
      if (fill && fill_q == PTR_W'(i)) ent_data_q[i] <= bus.rdata;
    end
    if (ale_take) begin
      ale_we_q    <= bus.in_we;
      ale_rd_q    <= bus.in_rd;
      ale_vaddr_q <= bus.in_addr;
    end
  end

  // Load lane select and sign/zero extension of the head entry
  always_comb begin
    lane = ent_data_q[head_q] >> {ent_off_q[head_q], 3'b000};
    case (ent_size_q[head_q])
      2'd0:    ext = ent_uns_q[head_q] ? DATA_W'(lane[7:0])  : DATA_W'($signed(lane[7:0]));
      2'd1:    ext = ent_uns_q[head_q] ? DATA_W'(lane[15:0]) : DATA_W'($signed(lane[15:0]));
      2'd2:    ext = ent_uns_q[head_q] ? DATA_W'(lane[31:0]) : DATA_W'($signed(lane[31:0]));
      default: ext = lane;
    endcase
  end

  // Response mux; all fields read 0 while nothing is being offered
  always_comb begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_rd    = '0;
    bus.resp_we    = 1'b0;
    bus.resp_ale   = 1'b0;
    bus.resp_vaddr = '0;
    if (ale_valid_q) begin
      bus.resp_valid = 1'b1;
      bus.resp_ale   = 1'b1;
      bus.resp_rd    = ale_rd_q;
      bus.resp_we    = ale_we_q;
      bus.resp_vaddr = ale_vaddr_q;
    end else if (head_live) begin
      bus.resp_valid = 1'b1;
      bus.resp_rd    = ent_rd_q[head_q];
      bus.resp_we    = ent_we_q[head_q];
      bus.resp_vaddr = ent_vaddr_q[head_q];
      bus.resp_data  = ent_we_q[head_q] ? '0 : ext;
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue (DATA_W=32, DEPTH=2).
module tb_mem_req_queue;

  logic clk;
  logic resetn;
  logic flush;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_req_queue_if #(.DATA_W(32), .ADDR_W(32), .RD_W(5)) bus ();

  mem_req_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .RD_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        ale;
    logic [3:0]  wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] data;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv_ld(input logic [31:0] a, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_we       = 1'b0;
    bus.in_size     = 2'd2;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = a;
    bus.in_wdata    = '0;
    bus.in_rd       = rd;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_we       = v.we;
    bus.in_size     = v.size;
    bus.in_unsigned = v.uns;
    bus.in_addr     = v.addr;
    bus.in_wdata    = v.wdata;
    bus.in_rd       = v.rd;
    bus.addr_ok     = ~v.ale;
    bus.data_ok     = 1'b0;
    bus.resp_ready  = 1'b0;
    #1;
    if (!v.ale) begin
      chk("vec_req", bus.req, 1);
      chk("vec_in_ready", bus.in_ready, 1);
      chk("vec_wr", bus.wr, v.we);
      chk("vec_size", bus.size, v.size);
      chk("vec_addr", bus.addr, v.addr);
      chk("vec_wstrb", bus.wstrb, v.wstrb);
      chk("vec_wdata", bus.wdata, v.bus_wdata);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b1;
      bus.rdata    = v.rdata;
      #1;
      chk("vec_resp_early", bus.resp_valid, 0);
      @(negedge clk);
      bus.data_ok    = 1'b0;
      bus.resp_ready = 1'b1;
      #1;
      chk("vec_resp_valid", bus.resp_valid, 1);
      chk("vec_resp_data", bus.resp_data, v.data);
      chk("vec_resp_rd", bus.resp_rd, v.rd);
      chk("vec_resp_we", bus.resp_we, v.we);
      chk("vec_resp_ale", bus.resp_ale, 0);
      chk("vec_resp_vaddr", bus.resp_vaddr, v.addr);
    end else begin
      chk("ale_req", bus.req, 0);
      chk("ale_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.resp_ready = 1'b1;
      #1;
      chk("ale_resp_valid", bus.resp_valid, 1);
      chk("ale_resp_ale", bus.resp_ale, 1);
      chk("ale_resp_vaddr", bus.resp_vaddr, v.addr);
      chk("ale_resp_rd", bus.resp_rd, v.rd);
      chk("ale_resp_data", bus.resp_data, 0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("vec_drained", bus.resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         we size uns addr          wdata         rd     rdata         ale wstrb    bus_wdata     data
    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0,         5'd3,  32'h8000_00F0, 1'b0, 4'b1111, 32'h0,         32'h8000_00F0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,         5'd4,  32'h8A00_0000, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF8A};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,         5'd5,  32'h8A00_0000, 1'b0, 4'b1000, 32'h0,         32'h0000_008A};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234, 5'd6,  32'h0,         1'b0, 4'b1100, 32'h1234_1234, 32'h0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,         5'd7,  32'h8001_7FFF, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2000, 32'h0,         5'd8,  32'h1234_8765, 1'b0, 4'b0011, 32'h0,         32'h0000_8765};
    vt[6]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 5'd9,  32'h0,         1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h0000_3004, 32'hDEAD_BEEF, 5'd10, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h0000_3002, 32'h0,         5'd11, 32'h00C3_0000, 1'b0, 4'b0100, 32'h0,         32'h0000_00C3};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0,         5'd12, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vt[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_2003, 32'h0000_5555, 5'd13, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vt[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,         5'd14, 32'h0000_007F, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};

    resetn          = 1'b0;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_we       = 1'b0;
    bus.in_size     = 2'd0;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = '0;
    bus.in_wdata    = '0;
    bus.in_rd       = '0;
    bus.addr_ok     = 1'b0;
    bus.data_ok     = 1'b0;
    bus.rdata       = '0;
    bus.resp_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    drv_ld(32'h0000_0040, 5'd1);
    #1;
    chk("rst_req", bus.req, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_ale", bus.resp_ale, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_rd", bus.resp_rd, 0);
    chk("rst_resp_vaddr", bus.resp_vaddr, 0);
    @(negedge clk);
    resetn       = 1'b1;
    bus.in_valid = 1'b0;

    // Single-operation vectors
    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Full queue: third load stalls until the first pops, responses in order
    @(negedge clk); drv_ld(32'h100, 5'd1); bus.addr_ok = 1'b1; #1;
    chk("full_req0", bus.req, 1);
    @(negedge clk); drv_ld(32'h104, 5'd2); #1;
    chk("full_req1", bus.req, 1);
    @(negedge clk); drv_ld(32'h108, 5'd3); bus.data_ok = 1'b1; bus.rdata = 32'h11; #1;
    chk("full_req2", bus.req, 0);
    chk("full_in_ready2", bus.in_ready, 0);
    @(negedge clk); bus.data_ok = 1'b0; bus.resp_ready = 1'b1; #1;
    chk("full_req3", bus.req, 0);
    chk("full_rv3", bus.resp_valid, 1);
    chk("full_rd3", bus.resp_rd, 1);
    chk("full_data3", bus.resp_data, 32'h11);
    @(negedge clk); bus.data_ok = 1'b1; bus.rdata = 32'h22; #1;
    chk("full_req4", bus.req, 1);
    chk("full_rv4", bus.resp_valid, 0);
    @(negedge clk); bus.in_valid = 1'b0; bus.addr_ok = 1'b0; bus.rdata = 32'h33; #1;
    chk("full_rv5", bus.resp_valid, 1);
    chk("full_rd5", bus.resp_rd, 2);
    chk("full_data5", bus.resp_data, 32'h22);
    @(negedge clk); bus.data_ok = 1'b0; #1;
    chk("full_rd6", bus.resp_rd, 3);
    chk("full_data6", bus.resp_data, 32'h33);
    @(negedge clk); bus.resp_ready = 1'b0; #1;
    chk("full_rv7", bus.resp_valid, 0);

    // Misaligned op waits for the queue to drain; ale blocks new requests
    @(negedge clk); drv_ld(32'h200, 5'd4); bus.addr_ok = 1'b1; #1;
    chk("alew_req0", bus.req, 1);
    @(negedge clk); drv_ld(32'h1001, 5'd7); #1;
    chk("alew_req1", bus.req, 0);
    chk("alew_rdy1", bus.in_ready, 0);
    @(negedge clk); bus.data_ok = 1'b1; bus.rdata = 32'h44; #1;
    chk("alew_rdy2", bus.in_ready, 0);
    @(negedge clk); bus.data_ok = 1'b0; bus.resp_ready = 1'b1; #1;
    chk("alew_rdy3", bus.in_ready, 0);
    chk("alew_rd3", bus.resp_rd, 4);
    chk("alew_data3", bus.resp_data, 32'h44);
    @(negedge clk); #1;
    chk("alew_rdy4", bus.in_ready, 1);
    chk("alew_rv4", bus.resp_valid, 0);
    @(negedge clk); drv_ld(32'h300, 5'd5); #1;
    chk("alew_rv5", bus.resp_valid, 1);
    chk("alew_ale5", bus.resp_ale, 1);
    chk("alew_vaddr5", bus.resp_vaddr, 32'h1001);
    chk("alew_rd5", bus.resp_rd, 7);
    chk("alew_req5", bus.req, 0);
    @(negedge clk); #1;
    chk("alew_req6", bus.req, 1);
    chk("alew_ale6", bus.resp_ale, 0);
    @(negedge clk); bus.in_valid = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h55; #1;
    @(negedge clk); bus.data_ok = 1'b0; #1;
    chk("alew_rd8", bus.resp_rd, 5);
    chk("alew_data8", bus.resp_data, 32'h55);
    @(negedge clk); bus.resp_ready = 1'b0; #1;
    chk("alew_rv9", bus.resp_valid, 0);

    // Flush with two loads outstanding, then a new load
    @(negedge clk); drv_ld(32'h400, 5'd8); bus.addr_ok = 1'b1; bus.resp_ready = 1'b1; #1;
    @(negedge clk); drv_ld(32'h404, 5'd9); #1;
    @(negedge clk); flush = 1'b1; drv_ld(32'h408, 5'd10); bus.data_ok = 1'b1; bus.rdata = 32'hAA; #1;
    chk("fl_req_f", bus.req, 0);
    chk("fl_rdy_f", bus.in_ready, 0);
    @(negedge clk); flush = 1'b0; bus.rdata = 32'hBB; #1;
    chk("fl_req_full", bus.req, 0);
    chk("fl_rv1", bus.resp_valid, 0);
    @(negedge clk); bus.data_ok = 1'b0; #1;
    chk("fl_req2", bus.req, 1);
    chk("fl_rdy2", bus.in_ready, 1);
    chk("fl_rv2", bus.resp_valid, 0);
    @(negedge clk); bus.in_valid = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hCC; #1;
    chk("fl_rv3", bus.resp_valid, 0);
    @(negedge clk); bus.data_ok = 1'b0; #1;
    chk("fl_rv4", bus.resp_valid, 1);
    chk("fl_rd4", bus.resp_rd, 10);
    chk("fl_data4", bus.resp_data, 32'hCC);
    @(negedge clk); bus.resp_ready = 1'b0; #1;
    chk("fl_rv5", bus.resp_valid, 0);

    // Stray data_ok on an empty queue is ignored
    @(negedge clk); bus.data_ok = 1'b1; bus.rdata = 32'hEE; #1;
    @(negedge clk); bus.data_ok = 1'b0; #1;
    chk("stray_rv", bus.resp_valid, 0);
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
